usb3_phy_tx_sched: RTL and testbench

- Scheduler in front of the USB 3.0 PHY transmit symbol path.
- Shares the single 10-bit TX symbol interface between three link-layer sources: link commands (LCMD), header packets (HP) and data packets (DP).
- Packets are atomic: once a packet starts, no other source can interrupt it.
- Also sequences electrical-idle entry and exit around traffic gaps, and polices starvation and runaway packet length.

---
 rtl/usb3_phy_tx_sched.sv | 176 +++++++++++++++++
 tb/tb_usb3_phy_tx_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb3_phy_tx_sched.sv
// USB3 PHY transmit scheduler: shares one 10-bit symbol lane between LCMD, HP and DP
// with atomic packets, electrical-idle sequencing, DP starvation override and length policing.
module usb3_phy_tx_sched #(
  parameter int unsigned IDLE_DLY    = 16,
  parameter int unsigned EI_EXIT_CYC = 4,
  parameter int unsigned STARVE_LIM  = 8,
  parameter int unsigned MAX_PKT     = 1100
) (
  input  logic       clk_phy,
  input  logic       rst_phy,
  input  logic [9:0] lcmd_data,
  input  logic       lcmd_valid,
  input  logic       lcmd_last,
  output logic       lcmd_ready,
  input  logic [9:0] hp_data,
  input  logic       hp_valid,
  input  logic       hp_last,
  output logic       hp_ready,
  input  logic [9:0] dp_data,
  input  logic       dp_valid,
  input  logic       dp_last,
  output logic       dp_ready,
  output logic [9:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_elec_idle,
  output logic [1:0] gnt_id,
  output logic       starve_evt,
  output logic       len_err
);

  localparam int unsigned IW = $clog2(IDLE_DLY + 1);
  localparam int unsigned WW = $clog2(EI_EXIT_CYC + 1);
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  localparam logic [IW-1:0] IDLE_END   = IW'(IDLE_DLY - 1);
  localparam logic [WW-1:0] WAKE_END   = WW'(EI_EXIT_CYC - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [10:0]   LEN_END    = 11'(MAX_PKT - 1);

  typedef enum logic [1:0] {ST_EI, ST_WAKE, ST_IDLE, ST_XFER} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_LCMD, SRC_HP, SRC_DP} src_t;

  state_t        state, state_nxt;
  src_t          owner, owner_nxt;
  logic [WW-1:0] wake_cnt, wake_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [10:0]   len_cnt, len_nxt;

  logic       any_valid;
  logic       own_valid;
  logic       own_last;
  logic [9:0] own_data;

  assign any_valid = lcmd_valid | hp_valid | dp_valid;
  assign gnt_id    = owner;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    case (owner)
      SRC_LCMD: begin own_valid = lcmd_valid; own_last = lcmd_last; own_data = lcmd_data; end
      SRC_HP:   begin own_valid = hp_valid;   own_last = hp_last;   own_data = hp_data;   end
      SRC_DP:   begin own_valid = dp_valid;   own_last = dp_last;   own_data = dp_data;   end
      default:  ;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    wake_nxt     = wake_cnt;
    idle_nxt     = idle_cnt;
    starve_nxt   = starve_cnt;
    len_nxt      = len_cnt;
    tx_elec_idle = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = '0;
    lcmd_ready   = 1'b0;
    hp_ready     = 1'b0;
    dp_ready     = 1'b0;
    starve_evt   = 1'b0;
    len_err      = 1'b0;

    case (state)
      ST_EI: begin
        tx_elec_idle = 1'b1;
        if (any_valid) begin
          state_nxt = ST_WAKE;
          wake_nxt  = '0;
        end
      end

      ST_WAKE: begin
        if (wake_cnt == WAKE_END) begin
          state_nxt = ST_IDLE;
          idle_nxt  = '0;
        end else begin
          wake_nxt = wake_cnt + 1'b1;
        end
      end

      ST_IDLE: begin
        // a request in the same cycle the idle timer expires takes precedence over EI entry
        if (any_valid) begin
          state_nxt = ST_XFER;
          idle_nxt  = '0;
          len_nxt   = '0;
          if (dp_valid && (starve_cnt >= STARVE_MAX)) begin
            owner_nxt  = SRC_DP;
            starve_evt = 1'b1;
          end else if (lcmd_valid) begin
            owner_nxt = SRC_LCMD;
          end else if (hp_valid) begin
            owner_nxt = SRC_HP;
          end else begin
            owner_nxt = SRC_DP;
          end
          if (owner_nxt == SRC_DP) begin
            starve_nxt = '0;
          end else if (dp_valid && (starve_cnt != STARVE_MAX)) begin
            starve_nxt = starve_cnt + 1'b1;
          end
        end else if (idle_cnt == IDLE_END) begin
          state_nxt = ST_EI;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end

      ST_XFER: begin
        tx_valid = own_valid;
        tx_data  = own_data;
        case (owner)
          SRC_LCMD: lcmd_ready = tx_ready;
          SRC_HP:   hp_ready   = tx_ready;
          SRC_DP:   dp_ready   = tx_ready;
          default:  ;
        endcase
        if (own_valid && tx_ready) begin
          if (own_last || (len_cnt == LEN_END)) begin
            len_err   = ~own_last;
            state_nxt = ST_IDLE;
            owner_nxt = SRC_NONE;
            idle_nxt  = '0;
          end else begin
            len_nxt = len_cnt + 1'b1;
          end
        end
      end

      default: state_nxt = ST_EI;
    endcase
  end

  always_ff @(posedge clk_phy or posedge rst_phy) begin
    if (rst_phy) begin
      state      <= ST_EI;
      owner      <= SRC_NONE;
      wake_cnt   <= '0;
      idle_cnt   <= '0;
      starve_cnt <= '0;
      len_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      wake_cnt   <= wake_nxt;
      idle_cnt   <= idle_nxt;
      starve_cnt <= starve_nxt;
      len_cnt    <= len_nxt;
    end
  end

endmodule

// File: tb/tb_usb3_phy_tx_sched.sv
// Self-checking bench for usb3_phy_tx_sched: directed scenarios plus randomized traffic
// scored against per-source symbol queues and a transaction-level arbitration model.
module tb_usb3_phy_tx_sched;

  localparam int unsigned MAX_PKT    = 1100;
  localparam int unsigned STARVE_LIM = 8;
  localparam int unsigned BUF_N      = 8192;

  logic       clk_phy = 1'b0;
  logic       rst_phy = 1'b1;
  logic [9:0] lcmd_data, hp_data, dp_data;
  logic       lcmd_valid, hp_valid, dp_valid;
  logic       lcmd_last, hp_last, dp_last;
  logic       lcmd_ready, hp_ready, dp_ready;
  logic [9:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       tx_elec_idle;
  logic [1:0] gnt_id;
  logic       starve_evt, len_err;

  // source drivers, indexed by grant id (1 = LCMD, 2 = HP, 3 = DP)
  logic       src_v [1:3];
  logic       src_l [1:3];
  logic [9:0] src_d [1:3];
  logic       src_r [1:3];
  logic       pop   [1:3];

  logic [10:0] sbuf  [1:3][0:BUF_N-1];
  int unsigned shead [1:3];
  int unsigned stail [1:3];
  int unsigned ehead [1:3];
  int unsigned nbeats[1:3];

  int unsigned gap      = 0;
  int unsigned rdy_mode = 0;
  int unsigned n_vec    = 0;
  int unsigned n_mis    = 0;

  // transaction-level model state
  int unsigned m_gnt, m_starve, m_gbeats, n_dec, last_dp_dec, n_sev;
  logic        m_v [1:3];
  logic        m_sev, m_end;

  assign lcmd_valid = src_v[1];
  assign hp_valid   = src_v[2];
  assign dp_valid   = src_v[3];
  assign lcmd_last  = src_l[1];
  assign hp_last    = src_l[2];
  assign dp_last    = src_l[3];
  assign lcmd_data  = src_d[1];
  assign hp_data    = src_d[2];
  assign dp_data    = src_d[3];
  assign src_r[1]   = lcmd_ready;
  assign src_r[2]   = hp_ready;
  assign src_r[3]   = dp_ready;

  always #5 clk_phy = ~clk_phy;

  usb3_phy_tx_sched #(
    .IDLE_DLY(16),
    .EI_EXIT_CYC(4),
    .STARVE_LIM(STARVE_LIM),
    .MAX_PKT(MAX_PKT)
  ) dut (
    .clk_phy(clk_phy),
    .rst_phy(rst_phy),
    .lcmd_data(lcmd_data),
    .lcmd_valid(lcmd_valid),
    .lcmd_last(lcmd_last),
    .lcmd_ready(lcmd_ready),
    .hp_data(hp_data),
    .hp_valid(hp_valid),
    .hp_last(hp_last),
    .hp_ready(hp_ready),
    .dp_data(dp_data),
    .dp_valid(dp_valid),
    .dp_last(dp_last),
    .dp_ready(dp_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_elec_idle(tx_elec_idle),
    .gnt_id(gnt_id),
    .starve_evt(starve_evt),
    .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_sym(input int s, input bit last, input logic [9:0] d);
    sbuf[s][stail[s] % BUF_N] = {last, d};
    stail[s]++;
  endtask

  task automatic push_pkt(input int s, input int unsigned len, input bit with_last);
    for (int unsigned i = 0; i < len; i++)
      push_sym(s, with_last && (i == len - 1), 10'($urandom));
  endtask

  task automatic clear_sources();
    for (int s = 1; s <= 3; s++) begin
      shead[s] = 0; stail[s] = 0; ehead[s] = 0;
      src_v[s] = 1'b0; src_l[s] = 1'b0; src_d[s] = '0; pop[s] = 1'b0;
    end
  endtask

  task automatic mon_reset();
    m_gnt = 0; m_starve = 0; m_gbeats = 0; m_sev = 1'b0; m_end = 1'b0;
    for (int s = 1; s <= 3; s++) m_v[s] = 1'b0;
  endtask

  task automatic drive();
    for (int s = 1; s <= 3; s++) begin
      if (pop[s]) shead[s]++;
      if (shead[s] != stail[s] && (gap == 0 || $urandom_range(99) >= gap)) begin
        src_v[s] = 1'b1;
        {src_l[s], src_d[s]} = sbuf[s][shead[s] % BUF_N];
      end else begin
        src_v[s] = 1'b0;
        src_l[s] = 1'($urandom);
        src_d[s] = 10'($urandom);
      end
    end
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = ($urandom_range(99) >= 30);
    endcase
  endtask

  // Reference rules: atomic grants, one bubble after a packet end, priority with
  // starvation override, symbols delivered in per-source order, length policing.
  task automatic monitor();
    bit          beat_end, exp_le, forced;
    int unsigned g, exp_w;
    logic [10:0] head;
    g = gnt_id;
    exp_le = 1'b0;
    beat_end = 1'b0;
    for (int s = 1; s <= 3; s++)
      chk($sformatf("ready%0d", s), src_r[s], (g == s) && tx_ready);
    if (g == 0) begin
      chk("txv_nogrant", tx_valid, 0);
      chk("txd_nogrant", tx_data, 0);
    end else begin
      chk("txv_owner", tx_valid, src_v[g]);
    end
    if (m_end) chk("bubble", g, 0);
    else if (m_gnt != 0) chk("atomic", g, m_gnt);
    forced = m_v[3] && (m_starve >= STARVE_LIM);
    if (m_gnt == 0 && g != 0) begin
      exp_w = forced ? 3 : (m_v[1] ? 1 : (m_v[2] ? 2 : 3));
      chk("arb", g, exp_w);
      chk("starve_evt", m_sev, forced);
      if (exp_w == 3) m_starve = 0;
      else if (m_v[3] && m_starve < STARVE_LIM) m_starve++;
      m_gbeats = 0;
      n_dec++;
      if (g == 3) last_dp_dec = n_dec;
    end else begin
      chk("starve_evt_quiet", m_sev, 0);
    end
    if (tx_valid && g != 0) begin
      if (ehead[g] >= stail[g]) begin
        chk("tx_extra", tx_valid, 0);
      end else begin
        head = sbuf[g][ehead[g] % BUF_N];
        chk("tx_data", tx_data, head[9:0]);
        if (tx_ready) begin
          exp_le = !head[10] && (m_gbeats == MAX_PKT - 1);
          beat_end = head[10] || exp_le;
          ehead[g]++;
          m_gbeats++;
          nbeats[g]++;
        end
      end
    end
    chk("len_err", len_err, exp_le);
    n_sev += starve_evt;
    m_gnt = g;
    m_sev = starve_evt;
    m_end = beat_end;
    for (int s = 1; s <= 3; s++) m_v[s] = src_v[s];
  endtask

  task automatic tick();
    @(posedge clk_phy);
    #1 drive();
    @(negedge clk_phy);
    for (int s = 1; s <= 3; s++) pop[s] = src_v[s] && src_r[s];
    if (!rst_phy) monitor();
  endtask

  task automatic wait_gnt(input int unsigned g, input int unsigned bound, input string tag);
    for (int unsigned i = 0; i < bound && gnt_id != g; i++) tick();
    chk(tag, gnt_id, g);
  endtask

  task automatic wait_drain(input int unsigned bound, input string tag);
    for (int unsigned i = 0; i < bound; i++) begin
      if (ehead[1] == stail[1] && ehead[2] == stail[2] && ehead[3] == stail[3] && gnt_id == 0)
        break;
      tick();
    end
    for (int s = 1; s <= 3; s++) chk($sformatf("%s_src%0d", tag, s), ehead[s], stail[s]);
  endtask

  initial begin
    int unsigned d0, s0, b0;
    bit seen;
    clear_sources();
    mon_reset();
    for (int s = 1; s <= 3; s++) nbeats[s] = 0;
    n_dec = 0; last_dp_dec = 0; n_sev = 0;

    #3;
    chk("rst_ei", tx_elec_idle, 1);
    chk("rst_txv", tx_valid, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_ready", {lcmd_ready, hp_ready, dp_ready}, 0);
    chk("rst_pulses", {starve_evt, len_err}, 0);
    @(posedge clk_phy);
    #1 rst_phy = 1'b0;

    // quiet after reset: stays in electrical idle
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("quiet_ei", tx_elec_idle, 1);
      chk("quiet_txv", tx_valid, 0);
      chk("quiet_gnt", gnt_id, 0);
    end

    // HP packet from EI: 4 wake cycles, decision, 3 beats, 16 idle cycles, back to EI
    push_sym(2, 1'b0, 10'h17C);
    push_sym(2, 1'b0, 10'h0AA);
    push_sym(2, 1'b1, 10'h155);
    for (int k = 0; k < 27; k++) begin
      tick();
      chk("hp_ei", tx_elec_idle, (k == 0) || (k >= 25));
      chk("hp_txv", tx_valid, (k >= 6) && (k <= 8));
      chk("hp_gnt", gnt_id, ((k >= 6) && (k <= 8)) ? 2 : 0);
      chk("hp_ready", hp_ready, (k >= 6) && (k <= 8));
      if (k == 6) chk("hp_sym0", tx_data, 10'h17C);
      if (k == 7) chk("hp_sym1", tx_data, 10'h0AA);
      if (k == 8) chk("hp_sym2", tx_data, 10'h155);
    end

    // LCMD beats DP; a late LCMD request cannot interrupt a DP packet
    push_pkt(1, 2, 1'b1);
    push_pkt(3, 3, 1'b1);
    wait_gnt(1, 20, "lcmd_first");
    wait_gnt(3, 20, "dp_second");
    push_pkt(1, 2, 1'b1);
    wait_gnt(1, 20, "lcmd_after_dp");
    chk("dp_done_before_lcmd", ehead[3], stail[3]);
    wait_drain(50, "drain_mix");

    // starvation: continuous LCMD/HP traffic with DP waiting
    d0 = n_dec; s0 = n_sev;
    for (int i = 0; i < 5; i++) begin
      push_pkt(1, 1, 1'b1);
      push_pkt(2, 1, 1'b1);
    end
    push_pkt(3, 2, 1'b1);
    wait_drain(100, "drain_starve");
    chk("starve_decision", last_dp_dec - d0, 9);
    chk("starve_pulses", n_sev - s0, 1);
    push_pkt(1, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    wait_gnt(1, 30, "starve_cleared");
    wait_drain(50, "drain_post_starve");

    // back-pressure: tx_ready toggling during a 5-symbol DP packet
    rdy_mode = 1;
    b0 = nbeats[3];
    push_pkt(3, 5, 1'b1);
    wait_drain(60, "drain_toggle");
    chk("toggle_beats", nbeats[3] - b0, 5);
    rdy_mode = 0;

    // runaway DP packet forced off at MAX_PKT, then reset mid-packet
    b0 = nbeats[3];
    push_pkt(3, 1103, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 1300 && !seen; i++) begin
      tick();
      seen = len_err;
    end
    chk("len_err_seen", seen, 1);
    chk("len_err_beat", nbeats[3] - b0, MAX_PKT);
    wait_gnt(3, 5, "len_rearb");
    chk("len_rearb_txv", tx_valid, 1);
    #2 rst_phy = 1'b1;
    #1;
    chk("async_txv", tx_valid, 0);
    chk("async_ei", tx_elec_idle, 1);
    chk("async_gnt", gnt_id, 0);
    chk("async_dpr", dp_ready, 0);
    clear_sources();
    mon_reset();
    @(posedge clk_phy);
    @(posedge clk_phy);
    #1 rst_phy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("post_rst_txv", tx_valid, 0);
      chk("post_rst_ei", tx_elec_idle, 1);
    end

    // randomized traffic with source gaps and random back-pressure
    gap = 25;
    rdy_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(99) < 6) begin
        int s;
        s = int'($urandom_range(3, 1));
        if (stail[s] - ehead[s] < 40) push_pkt(s, $urandom_range(6, 1), 1'b1);
      end
      tick();
    end
    wait_drain(3000, "drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
